// File: rtl/pc060ha_pkg.sv
// Shared types and constants for the PC060HA master-side sequencer.
// Reply states exist only when PC060HA_REPLY_EN is defined.
package pc060ha_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POLL_IDX,
        ST_POLL_RD,
        ST_SEND_IDX,
        ST_SEND_LO,
        ST_SEND_HI,
        ST_DONE
`ifdef PC060HA_REPLY_EN
        ,
        ST_REPLY_IDX,
        ST_REPLY_RD,
        ST_RX_IDX,
        ST_RX_LO,
        ST_RX_HI
`endif
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_RELEASE
    } bus_phase_e;

    localparam logic [3:0] REG_DATA_LO = 4'd0;
    localparam logic [3:0] REG_DATA_HI = 4'd1;
    localparam logic [3:0] REG_STATUS  = 4'd4;

    localparam int FLAG_M2S_PENDING = 0;
    localparam int FLAG_S2M_READY   = 2;

    // Every state except IDLE and DONE owns exactly one bus access.
    function automatic logic is_access_state(state_e s);
        return !(s inside {ST_IDLE, ST_DONE});
    endfunction

endpackage

// File: rtl/pc060ha_bus_cycle.sv
// One PC060HA master bus access: setup, BUS_WAIT strobe cycles, release.
// The cycle after release is idle (nMCS=1) and is where the next start is accepted.
module pc060ha_bus_cycle
    import pc060ha_pkg::*;
#(
    parameter int BUS_WAIT = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       rd_i,
    input  logic       a0_i,
    input  logic [3:0] wdata_i,
    input  logic [3:0] md_in_i,
    output logic       idle_o,
    output logic       done_o,
    output logic [3:0] rdata_o,
    output logic       nmcs_o,
    output logic       nmrd_o,
    output logic       nmwr_o,
    output logic       ma0_o,
    output logic [3:0] md_out_o,
    output logic       md_oe_o
);

    localparam logic [3:0] WAIT_LAST = 4'(BUS_WAIT - 1);

    bus_phase_e phase_q, phase_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rd_q, rd_d;
    logic       a0_q, a0_d;
    logic [3:0] wdata_q, wdata_d;
    logic [3:0] rdata_q, rdata_d;
    logic       busy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            a0_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            a0_q    <= a0_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        a0_d    = a0_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (phase_q)
            PH_IDLE: begin
                if (start_i) begin
                    phase_d = PH_SETUP;
                    rd_d    = rd_i;
                    a0_d    = a0_i;
                    wdata_d = wdata_i;
                end
            end
            PH_SETUP: begin
                phase_d = PH_STROBE;
                cnt_d   = WAIT_LAST;
            end
            PH_STROBE: begin
                // The slave drives MD_IN for the whole strobe; take it on the last cycle.
                if (cnt_q == 4'd0) begin
                    phase_d = PH_RELEASE;
                    if (rd_q) begin
                        rdata_d = md_in_i;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            PH_RELEASE: begin
                phase_d = PH_IDLE;
            end
            default: begin
                phase_d = PH_IDLE;
            end
        endcase
    end

    assign busy     = (phase_q != PH_IDLE);
    assign idle_o   = !busy;
    assign done_o   = (phase_q == PH_RELEASE);
    assign rdata_o  = rdata_q;
    assign nmcs_o   = !busy;
    assign nmrd_o   = !((phase_q == PH_STROBE) && rd_q);
    assign nmwr_o   = !((phase_q == PH_STROBE) && !rd_q);
    assign ma0_o    = busy && a0_q;
    assign md_oe_o  = busy && !rd_q;
    assign md_out_o = wdata_q;

endmodule

// File: rtl/pc060ha_master_seq.sv
// Master-side command sequencer for the PC060HA sound communication chip.
// Optional reply path (REPLY_IDX..RX_HI) is built when PC060HA_REPLY_EN is defined.
module pc060ha_master_seq
    import pc060ha_pkg::*;
#(
    parameter int BUS_WAIT   = 2,
    parameter int POLL_LIMIT = 255
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       err,
    output logic       nMCS,
    output logic       nMRD,
    output logic       nMWR,
    output logic       MA0,
    output logic [3:0] MD_OUT,
    output logic       MD_OE,
    input  logic [3:0] MD_IN
);

    localparam logic [8:0] POLL_LAST = 9'(POLL_LIMIT);

    state_e     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] poll_q, poll_d;
    logic       err_q, err_d;
    logic [8:0] poll_next;

    logic       bus_start;
    logic       bus_rd;
    logic       bus_a0;
    logic [3:0] bus_wdata;
    logic       bus_idle;
    logic       bus_done;
    logic [3:0] bus_rdata;

`ifdef PC060HA_REPLY_EN
    logic [3:0] rx_lo_q, rx_lo_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
`else
    logic [2:0] unused_rdata;
    assign unused_rdata = bus_rdata[3:1];
`endif

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            poll_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            poll_q  <= poll_d;
            err_q   <= err_d;
        end
    end

`ifdef PC060HA_REPLY_EN
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            rx_lo_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rx_lo_q     <= rx_lo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        poll_d    = poll_q;
        err_d     = 1'b0;
        poll_next = {1'b0, poll_q} + 9'd1;
`ifdef PC060HA_REPLY_EN
        rx_lo_d     = rx_lo_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d   = cmd_data;
                    poll_d  = '0;
                    state_d = ST_POLL_IDX;
                end
            end
            ST_POLL_IDX: if (bus_done) state_d = ST_POLL_RD;
            ST_POLL_RD: begin
                if (bus_done) begin
                    if (bus_rdata[FLAG_M2S_PENDING]) begin
                        // Slave still holds the previous command: retry or give up.
                        if (poll_next == POLL_LAST) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            poll_d  = poll_next[7:0];
                            state_d = ST_POLL_IDX;
                        end
                    end else begin
                        state_d = ST_SEND_IDX;
                    end
                end
            end
            ST_SEND_IDX: if (bus_done) state_d = ST_SEND_LO;
            ST_SEND_LO:  if (bus_done) state_d = ST_SEND_HI;
            ST_SEND_HI:  if (bus_done) state_d = ST_DONE;
`ifdef PC060HA_REPLY_EN
            ST_DONE: begin
                poll_d  = '0;
                state_d = ST_REPLY_IDX;
            end
            ST_REPLY_IDX: if (bus_done) state_d = ST_REPLY_RD;
            ST_REPLY_RD: begin
                if (bus_done) begin
                    if (bus_rdata[FLAG_S2M_READY]) begin
                        state_d = ST_RX_IDX;
                    end else if (poll_next == POLL_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        poll_d  = poll_next[7:0];
                        state_d = ST_REPLY_IDX;
                    end
                end
            end
            ST_RX_IDX: if (bus_done) state_d = ST_RX_LO;
            ST_RX_LO: begin
                if (bus_done) begin
                    rx_lo_d = bus_rdata;
                    state_d = ST_RX_HI;
                end
            end
            ST_RX_HI: begin
                if (bus_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = {bus_rdata, rx_lo_q};
                    state_d     = ST_IDLE;
                end
            end
`else
            ST_DONE: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Access parameters follow the state being entered, so a new access can
    // start in the idle cycle that closes the previous one.
    always_comb begin
        bus_rd    = 1'b0;
        bus_a0    = 1'b0;
        bus_wdata = '0;
        case (state_d)
            ST_POLL_IDX: bus_wdata = REG_STATUS;
            ST_POLL_RD: begin
                bus_rd = 1'b1;
                bus_a0 = 1'b1;
            end
            ST_SEND_IDX: bus_wdata = REG_DATA_LO;
            ST_SEND_LO: begin
                bus_a0    = 1'b1;
                bus_wdata = cmd_d[3:0];
            end
            ST_SEND_HI: begin
                bus_a0    = 1'b1;
                bus_wdata = cmd_d[7:4];
            end
`ifdef PC060HA_REPLY_EN
            ST_REPLY_IDX: bus_wdata = REG_STATUS;
            ST_REPLY_RD: begin
                bus_rd = 1'b1;
                bus_a0 = 1'b1;
            end
            ST_RX_IDX: bus_wdata = REG_DATA_LO;
            ST_RX_LO, ST_RX_HI: begin
                bus_rd = 1'b1;
                bus_a0 = 1'b1;
            end
`endif
            default: begin
                bus_rd    = 1'b0;
                bus_a0    = 1'b0;
                bus_wdata = '0;
            end
        endcase
    end

    assign bus_start = bus_idle && is_access_state(state_d);

    pc060ha_bus_cycle #(
        .BUS_WAIT(BUS_WAIT)
    ) u_bus (
        .clk_i    (MCLK),
        .rst_i    (RESET),
        .start_i  (bus_start),
        .rd_i     (bus_rd),
        .a0_i     (bus_a0),
        .wdata_i  (bus_wdata),
        .md_in_i  (MD_IN),
        .idle_o   (bus_idle),
        .done_o   (bus_done),
        .rdata_o  (bus_rdata),
        .nmcs_o   (nMCS),
        .nmrd_o   (nMRD),
        .nmwr_o   (nMWR),
        .ma0_o    (MA0),
        .md_out_o (MD_OUT),
        .md_oe_o  (MD_OE)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign err       = err_q;

`ifdef PC060HA_REPLY_EN
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
`else
    assign rsp_valid = 1'b0;
    assign rsp_data  = 8'h00;
`endif

endmodule
